spi_reader: RTL and testbench

SPI_READER -- requirements
Module: spi_reader

---
 rtl/spi_reader.sv | 124 ++++++++++++
 tb/tb_spi_reader.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_reader.sv
// SPI mode-0 master: shifts one request byte out on spi__do while capturing one byte from spi__di.
// Every SPI pin is driven straight from a flop, so the next-state logic also computes next pin values.
module spi_reader #(
  parameter int unsigned HALF = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req__valid,
  output logic       req__ready,
  input  logic [7:0] req__data,
  output logic       resp__valid,
  input  logic       resp__ready,
  output logic [7:0] resp__data,
  output logic       spi__sclk,
  output logic       spi__cs,
  output logic       spi__do,
  input  logic       spi__di
);

  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, DONE} state_t;

  localparam logic [7:0] DIV_LOAD = 8'(HALF - 1);

  state_t     state, state_nxt;
  logic [7:0] div, div_nxt;
  logic [2:0] bit_cnt, bit_cnt_nxt;
  logic [7:0] tx, tx_nxt;
  logic [7:0] rx, rx_nxt;
  logic       sclk_nxt, cs_nxt, do_nxt, valid_nxt;
  logic [7:0] data_nxt;
  logic       tick;

  assign tick       = (div == 8'd0);
  assign req__ready = (state == IDLE);

  always_comb begin
    state_nxt   = state;
    div_nxt     = div - 8'd1;
    bit_cnt_nxt = bit_cnt;
    tx_nxt      = tx;
    rx_nxt      = rx;
    sclk_nxt    = spi__sclk;
    cs_nxt      = spi__cs;
    do_nxt      = spi__do;
    valid_nxt   = resp__valid;
    data_nxt    = resp__data;

    case (state)
      IDLE: begin
        if (req__valid) begin
          state_nxt   = SETUP;
          div_nxt     = DIV_LOAD;
          bit_cnt_nxt = 3'd7;
          tx_nxt      = req__data;
          rx_nxt      = 8'h00;
          cs_nxt      = 1'b0;
          sclk_nxt    = 1'b0;
          do_nxt      = req__data[7];
        end
      end
      SETUP, LOW: begin
        if (tick) begin
          state_nxt = HIGH;
          div_nxt   = DIV_LOAD;
          sclk_nxt  = 1'b1;
        end
      end
      HIGH: begin
        if (tick) begin
          rx_nxt   = {rx[6:0], spi__di};
          div_nxt  = DIV_LOAD;
          sclk_nxt = 1'b0;
          if (bit_cnt == 3'd0) begin
            state_nxt = DONE;
            cs_nxt    = 1'b1;
            do_nxt    = 1'b0;
            data_nxt  = {rx[6:0], spi__di};
          end else begin
            state_nxt   = LOW;
            tx_nxt      = {tx[6:0], 1'b0};
            do_nxt      = tx[6];
            bit_cnt_nxt = bit_cnt - 3'd1;
          end
        end
      end
      DONE: begin
        // resp__valid rises one cycle after DONE entry; the handshake uses the flopped valid.
        valid_nxt = 1'b1;
        if (resp__valid && resp__ready) begin
          state_nxt = IDLE;
          valid_nxt = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      div         <= 8'd0;
      bit_cnt     <= 3'd0;
      tx          <= 8'h00;
      rx          <= 8'h00;
      spi__sclk   <= 1'b0;
      spi__cs     <= 1'b1;
      spi__do     <= 1'b0;
      resp__valid <= 1'b0;
      resp__data  <= 8'h00;
    end else begin
      state       <= state_nxt;
      div         <= div_nxt;
      bit_cnt     <= bit_cnt_nxt;
      tx          <= tx_nxt;
      rx          <= rx_nxt;
      spi__sclk   <= sclk_nxt;
      spi__cs     <= cs_nxt;
      spi__do     <= do_nxt;
      resp__valid <= valid_nxt;
      resp__data  <= data_nxt;
    end
  end

endmodule

// File: tb/tb_spi_reader.sv
// Directed bench for spi_reader: HALF=2 instance for data/timing/reset cases, HALF=1 instance for back-to-back.
module tb_spi_reader;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset;
  logic       req_valid, req_ready, resp_valid, resp_ready;
  logic [7:0] req_data, resp_data;
  logic       sclk, cs, mosi, di;

  logic       req_valid_b, req_ready_b, resp_valid_b;
  logic       resp_ready_b = 1'b1;
  logic [7:0] req_data_b, resp_data_b;
  logic       sclk_b, cs_b, mosi_b;
  logic       di_b = 1'b1;

  spi_reader #(.HALF(2)) dut (
    .clock(clock), .reset(reset),
    .req__valid(req_valid), .req__ready(req_ready), .req__data(req_data),
    .resp__valid(resp_valid), .resp__ready(resp_ready), .resp__data(resp_data),
    .spi__sclk(sclk), .spi__cs(cs), .spi__do(mosi), .spi__di(di)
  );

  spi_reader #(.HALF(1)) dut_b (
    .clock(clock), .reset(reset),
    .req__valid(req_valid_b), .req__ready(req_ready_b), .req__data(req_data_b),
    .resp__valid(resp_valid_b), .resp__ready(resp_ready_b), .resp__data(resp_data_b),
    .spi__sclk(sclk_b), .spi__cs(cs_b), .spi__do(mosi_b), .spi__di(di_b)
  );

  int tests = 0;
  int fails = 0;

  // Bus monitor and SPI slave model for the HALF=2 instance, sampled 1 time unit after each edge.
  int         rises = 0, hi_bad = 0, lo_bad = 0, hi_run = 0, lo_run = 0;
  int         cs_run = 0, last_cs_run = 0;
  int         sbit = 7;
  logic [7:0] do_bits = 8'h00;
  logic [7:0] slave_byte = 8'h00;
  logic       sclk_q = 1'b0, cs_q = 1'b1;
  logic       di_model = 1'b0, di_const = 1'b1;

  always @(posedge clock) begin
    #1;
    if (!sclk_q && sclk) begin
      do_bits = {do_bits[6:0], mosi};
      rises++;
      if (lo_run != 2) lo_bad++;
    end
    if (sclk_q && !sclk && hi_run != 2) hi_bad++;
    hi_run = sclk ? hi_run + 1 : 0;
    lo_run = (!sclk && !cs) ? lo_run + 1 : 0;
    if (!cs_q && cs) last_cs_run = cs_run;
    cs_run = cs ? 0 : cs_run + 1;
    // Mode-0 slave: first bit valid before the first rising edge, advance on each falling edge.
    if (cs) sbit = 7;
    else if (sclk_q && !sclk) sbit = sbit - 1;
    di = di_model ? slave_byte[sbit[2:0]] : di_const;
    sclk_q = sclk;
    cs_q   = cs;
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Accept one request, then wait (bounded) for resp_valid; optionally wiggle other inputs meanwhile.
  task automatic run_txn(input logic [7:0] d, input bit noisy, output int lat, output int rr);
    req_data  = d;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    lat = 0;
    rr  = 0;
    while (resp_valid !== 1'b1 && lat < 100) begin
      if (noisy) begin
        req_valid  = (lat % 3 == 0);
        req_data   = 8'hFF;
        resp_ready = (lat % 2 == 1);
      end
      tick();
      lat++;
      if (req_ready !== 1'b0) rr++;
    end
    req_valid  = 1'b0;
    resp_ready = 1'b0;
  endtask

  task automatic handshake();
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
  endtask

  int lat, rr, r0, hb0, lb0, n, m, bad;

  initial begin
    reset       = 1'b1;
    req_valid   = 1'b0;
    req_data    = 8'h00;
    resp_ready  = 1'b0;
    req_valid_b = 1'b0;
    req_data_b  = 8'h00;
    repeat (3) tick();
    reset = 1'b0;

    chk("rst_cs", cs, 1);
    chk("rst_sclk", sclk, 0);
    chk("rst_do", mosi, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_data", resp_data, 8'h00);
    chk("rst_req_ready", req_ready, 1);

    // 0xA5 out, slave returns 0x3C, with req_valid/resp_ready noise during the transfer.
    slave_byte = 8'h3C;
    di_model   = 1'b1;
    r0 = rises; hb0 = hi_bad; lb0 = lo_bad;
    run_txn(8'hA5, 1'b1, lat, rr);
    chk("a_latency", lat, 33);
    chk("a_do_bits", do_bits, 8'hA5);
    chk("a_rises", rises - r0, 8);
    chk("a_resp_data", resp_data, 8'h3C);
    chk("a_no_reaccept", rr, 0);
    chk("a_cs_low_run", last_cs_run, 32);
    chk("a_high_width", hi_bad - hb0, 0);
    chk("a_low_width", lo_bad - lb0, 0);

    bad = 0;
    repeat (10) begin
      tick();
      if (resp_valid !== 1'b1 || resp_data !== 8'h3C || req_ready !== 1'b0) bad++;
    end
    chk("bp_stable", bad, 0);
    handshake();
    chk("bp_release_valid", resp_valid, 0);
    chk("bp_release_ready", req_ready, 1);
    chk("bp_data_hold", resp_data, 8'h3C);

    // 0x00 out with spi__di held high.
    di_model = 1'b0;
    di_const = 1'b1;
    r0 = rises; hb0 = hi_bad; lb0 = lo_bad;
    run_txn(8'h00, 1'b0, lat, rr);
    chk("b_latency", lat, 33);
    chk("b_do_bits", do_bits, 8'h00);
    chk("b_rises", rises - r0, 8);
    chk("b_resp_data", resp_data, 8'hFF);
    chk("b_high_width", hi_bad - hb0, 0);
    chk("b_low_width", lo_bad - lb0, 0);
    handshake();

    // Abort with reset during the 4th HIGH phase.
    di_model   = 1'b1;
    slave_byte = 8'h55;
    r0 = rises;
    req_data  = 8'h55;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    n = 0;
    while (!((rises - r0) == 4 && sclk === 1'b1) && n < 100) begin
      tick();
      n++;
    end
    chk("abort_reach_high4", rises - r0, 4);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_cs", cs, 1);
    chk("abort_sclk", sclk, 0);
    chk("abort_valid", resp_valid, 0);
    chk("abort_req_ready", req_ready, 1);
    bad = 0;
    repeat (40) begin
      tick();
      if (resp_valid !== 1'b0) bad++;
    end
    chk("abort_no_resp", bad, 0);
    chk("abort_resp_data", resp_data, 8'h00);

    slave_byte = 8'h96;
    run_txn(8'h81, 1'b0, lat, rr);
    chk("c_latency", lat, 33);
    chk("c_do_bits", do_bits, 8'h81);
    chk("c_resp_data", resp_data, 8'h96);
    handshake();

    // HALF=1 back-to-back with resp_ready tied high.
    req_data_b  = 8'h5A;
    req_valid_b = 1'b1;
    tick();
    n = 0;
    while (resp_valid_b !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk("h1_latency_1", n, 17);
    chk("h1_resp_data", resp_data_b, 8'hFF);
    m = 0;
    n = 0;
    while (cs_b !== 1'b0 && n < 10) begin
      tick();
      n++;
      if (req_ready_b === 1'b1) m++;
    end
    chk("h1_idle_cycles", m, 1);
    n = 0;
    while (resp_valid_b !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk("h1_latency_2", n, 17);
    chk("h1_done_sclk", sclk_b, 0);
    chk("h1_done_do", mosi_b, 0);
    req_valid_b = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
